if_stage_fq: RTL and testbench
==============================

# if_stage_fq

Parametrised instruction-fetch stage with a decoupled fetch queue. It sits between the branch unit and the decode stage, and talks to an instruction SRAM-like bus with a split request/response handshake (req/addr_ok, data_ok). Unlike a single-register IF stage, it keeps several fetches in flight and buffers up to FQ_DEPTH instructions. It also cancels wrong-path responses on redirect and reports misaligned-PC fetch exceptions in-band to decode.

## Interface
- RESET_PC, 32'hbfc00000, first fetch address after reset.
- FQ_DEPTH, 4, fetch-queue entries; power of two, ≥2. It also bounds outstanding requests.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- br_stall  in  1  hold off issuing new requests.
- br_taken  in  1  one-cycle redirect pulse.
- br_target  in  32  redirect PC.
- ds_allowin  in  1  decode accepts this cycle.
- fs_to_ds_valid  out  1  queue head valid.
- fs_to_ds_bus  out  65  {adel, inst[31:0], pc[31:0]}.
- inst_sram_req  out  1  fetch request.
- inst_sram_wr  out  1  constant 0.
- inst_sram_size  out  2  constant 2'd2.
- inst_sram_wstrb  out  4  constant 0.
- inst_sram_wdata  out  32  constant 0.
- inst_sram_addr  out  32  fetch address.
- inst_sram_addr_ok  in  1  request accepted (req & addr_ok).
- inst_sram_data_ok  in  1  response valid; responses return in request order.
- inst_sram_rdata  in  32  response instruction.

## Operation
- State:
  - fetch_pc: next address to request.
  - pend FIFO: PCs of accepted requests, FQ_DEPTH deep.
  - out_cnt: outstanding requests.
  - disc_cnt: responses still to drop.
  - fq: queue of FQ_DEPTH × 65 bits, with head/tail pointers and count q_cnt.
  - halt: set after an adel entry is queued.
- Credit rule: a request may issue only if q_cnt + out_cnt < FQ_DEPTH. Every non-discarded response therefore has a free queue slot, and fq never overflows.
- Issue:
  - inst_sram_req = !halt & fetch_pc[1:0]==0 & credit & (!br_stall | req_pending).
  - inst_sram_addr = fetch_pc.
  - Once req is asserted and not yet accepted, it is held (req_pending), and the address stays stable unless a redirect occurs.
- Accept (req & addr_ok): push fetch_pc into pend; out_cnt+1; fetch_pc += 4, wrapping modulo 2^32.
- Response (data_ok): pop pend; out_cnt−1.
  - If disc_cnt > 0: decrement disc_cnt and drop the response.
  - Otherwise: push {1'b0, rdata, pend_head_pc} into fq.
- Misaligned fetch_pc (fetch_pc[1:0] != 0):
  - No bus request is made.
  - Once out_cnt==0, disc_cnt==0 and credit is available, push {1'b1, 32'h0, fetch_pc} and set halt.
  - halt blocks all issue until a redirect.
- Dequeue: fs_to_ds_valid = q_cnt != 0. The head pops when fs_to_ds_valid & ds_allowin. Push and pop in the same cycle leave q_cnt unchanged.
- Redirect (br_taken), which overrides everything else in that cycle:
  - fetch_pc <= br_target; halt <= 0; fq flushed (q_cnt <= 0, no push, no pop credited to decode).
  - disc_cnt <= disc_cnt + out_cnt + accept − data_ok. Both the request accepted this cycle and all in-flight requests become wrong-path.
  - The data_ok arriving this cycle is dropped. disc_cnt is clamped to never go negative; the formula is exact because data_ok consumes an old disc or out entry first.
  - req_pending clears. Any req asserted this cycle but not accepted reissues next cycle with br_target.
- br_stall with no pending request: req is 0 and queued entries still drain.

## Timing
- Reset values: fetch_pc=RESET_PC, q_cnt=out_cnt=disc_cnt=0, halt=0, fs_to_ds_valid=0, inst_sram_req=0 during the reset cycle. fs_to_ds_bus is 0 while fs_to_ds_valid=0.
- Reset mid-operation drops all state in one cycle. Late data_ok pulses after reset are not counted; the bus is reset together with this block.
- The first cycle after reset deasserts drives req=1, addr=RESET_PC (combinational from state).
- Response latency: data_ok in cycle M gives fs_to_ds_valid in M+1 with that instruction. The path is registered; there is no rdata bypass.
- Redirect latency: br_taken in cycle T gives req with addr=br_target in T+1. fs_to_ds_valid=0 in T+1 unless fq was refilled, which is impossible that early.
- Throughput: one instruction per cycle when addr_ok and data_ok are continuously high and FQ_DEPTH ≥2.

## Test plan
- Reset, memory with addr_ok=1 and data_ok one cycle after accept, ds_allowin=1 → decode sees PCs bfc00000, bfc00004, … one per cycle, adel=0.
- ds_allowin=0 for 10 cycles with FQ_DEPTH=4 → at most 4 accepted requests, q_cnt=4, req=0. On release, PCs are in order with none lost or duplicated.
- Three requests outstanding, br_taken with br_target=0x1000 while data_ok=1 → all three old responses dropped, next req addr=0x1000, and the first entry delivered to decode has pc=0x1000.
- br_target=0x1002 → no bus req, one entry {adel=1, inst=0, pc=0x1002}, then the stage idles. A later br_taken to 0x2000 resumes fetching.
- br_stall=1 while req is pending and addr_ok is delayed 3 cycles → req and addr are held until accepted, and no new req issues while stalled.
- Reset asserted with requests in flight → next cycle fs_to_ds_valid=0 and req=0, then fetch restarts at bfc00000.

Source files
------------

// File: rtl/if_stage_fq.sv
// Instruction-fetch stage with a decoupled fetch queue.
// Keeps several fetches in flight on a split req/addr_ok, data_ok bus, buffers
// up to FQ_DEPTH instructions for decode, drops wrong-path responses after a
// redirect and reports misaligned fetch PCs in-band as adel entries.
module if_stage_fq #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000,
    parameter int unsigned FQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        br_stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        ds_allowin,
    output logic        fs_to_ds_valid,
    output logic [64:0] fs_to_ds_bus,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_addr,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata
);

    localparam int unsigned PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    // Discard counter is wider than the queue counters: repeated redirects can
    // stack up several generations of wrong-path requests on a slow bus.
    localparam int unsigned DW = CW + 4;

    typedef struct packed {
        logic        adel;
        logic [31:0] inst;
        logic [31:0] pc;
    } fq_entry_t;

    // Architectural state
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   pend_mem_q [FQ_DEPTH];
    logic [31:0]   pend_mem_d [FQ_DEPTH];
    logic [PW-1:0] pend_rd_q, pend_rd_d;
    logic [PW-1:0] pend_wr_q, pend_wr_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic [DW-1:0] disc_cnt_q, disc_cnt_d;
    fq_entry_t     fq_mem_q [FQ_DEPTH];
    fq_entry_t     fq_mem_d [FQ_DEPTH];
    logic [PW-1:0] fq_rd_q, fq_rd_d;
    logic [PW-1:0] fq_wr_q, fq_wr_d;
    logic [CW-1:0] q_cnt_q, q_cnt_d;
    logic          halt_q, halt_d;
    logic          req_pending_q, req_pending_d;

    // Per-cycle control
    logic [CW:0]   inflight;
    logic          credit;
    logic          misaligned;
    logic          req_c;
    logic          accept;
    logic          resp_drop;
    logic          resp_keep;
    logic          adel_push;
    logic          fq_push;
    logic          fq_pop;
    fq_entry_t     push_entry;
    logic [DW:0]   disc_sum;

    // Issue / accept / response qualification
    always_comb begin
        inflight   = {1'b0, q_cnt_q} + {1'b0, out_cnt_q};
        credit     = inflight < (CW+1)'(FQ_DEPTH);
        misaligned = fetch_pc_q[1:0] != 2'b00;
        req_c      = !reset && !halt_q && !misaligned && credit
                     && (!br_stall || req_pending_q);
        accept     = req_c && inst_sram_addr_ok;
        resp_drop  = inst_sram_data_ok && (disc_cnt_q != '0);
        // A response with nothing outstanding (e.g. a straggler from before
        // reset) is ignored rather than allowed to corrupt the counters.
        resp_keep  = inst_sram_data_ok && (disc_cnt_q == '0) && (out_cnt_q != '0);
        adel_push  = !halt_q && misaligned && (out_cnt_q == '0)
                     && (disc_cnt_q == '0) && credit;
        fq_pop     = fs_to_ds_valid && ds_allowin;
        fq_push    = resp_keep || adel_push;
        if (adel_push) begin
            push_entry = '{adel: 1'b1, inst: 32'h0, pc: fetch_pc_q};
        end else begin
            push_entry = '{adel: 1'b0, inst: inst_sram_rdata, pc: pend_mem_q[pend_rd_q]};
        end
    end

    // Next-state: redirect overrides all normal bookkeeping in its cycle
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        pend_mem_d    = pend_mem_q;
        pend_rd_d     = pend_rd_q;
        pend_wr_d     = pend_wr_q;
        out_cnt_d     = out_cnt_q;
        disc_cnt_d    = disc_cnt_q;
        fq_mem_d      = fq_mem_q;
        fq_rd_d       = fq_rd_q;
        fq_wr_d       = fq_wr_q;
        q_cnt_d       = q_cnt_q;
        halt_d        = halt_q;
        req_pending_d = req_pending_q;
        disc_sum      = '0;

        if (br_taken) begin
            fetch_pc_d    = br_target;
            halt_d        = 1'b0;
            req_pending_d = 1'b0;
            fq_rd_d       = '0;
            fq_wr_d       = '0;
            q_cnt_d       = '0;
            pend_rd_d     = '0;
            pend_wr_d     = '0;
            out_cnt_d     = '0;
            // Everything in flight, including this cycle's accept, turns into
            // wrong-path traffic; this cycle's response retires one of them.
            disc_sum = {1'b0, disc_cnt_q} + (DW+1)'(out_cnt_q) + (DW+1)'(accept);
            if (inst_sram_data_ok && (disc_sum != '0)) begin
                disc_sum = disc_sum - (DW+1)'(1);
            end
            if (disc_sum[DW]) begin
                disc_cnt_d = '1;
            end else begin
                disc_cnt_d = disc_sum[DW-1:0];
            end
        end else begin
            if (accept) begin
                pend_mem_d[pend_wr_q] = fetch_pc_q;
                pend_wr_d             = pend_wr_q + PW'(1);
                fetch_pc_d            = fetch_pc_q + 32'd4;
                req_pending_d         = 1'b0;
            end else if (req_c) begin
                req_pending_d = 1'b1;
            end

            if (resp_drop) begin
                disc_cnt_d = disc_cnt_q - DW'(1);
            end
            if (resp_keep) begin
                pend_rd_d = pend_rd_q + PW'(1);
            end

            if (fq_push) begin
                fq_mem_d[fq_wr_q] = push_entry;
                fq_wr_d           = fq_wr_q + PW'(1);
            end
            if (fq_pop) begin
                fq_rd_d = fq_rd_q + PW'(1);
            end

            if (adel_push) begin
                halt_d = 1'b1;
            end

            out_cnt_d = out_cnt_q + CW'(accept) - CW'(resp_keep);
            q_cnt_d   = q_cnt_q + CW'(fq_push) - CW'(fq_pop);
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            pend_rd_q     <= '0;
            pend_wr_q     <= '0;
            out_cnt_q     <= '0;
            disc_cnt_q    <= '0;
            fq_rd_q       <= '0;
            fq_wr_q       <= '0;
            q_cnt_q       <= '0;
            halt_q        <= 1'b0;
            req_pending_q <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            pend_rd_q     <= pend_rd_d;
            pend_wr_q     <= pend_wr_d;
            out_cnt_q     <= out_cnt_d;
            disc_cnt_q    <= disc_cnt_d;
            fq_rd_q       <= fq_rd_d;
            fq_wr_q       <= fq_wr_d;
            q_cnt_q       <= q_cnt_d;
            halt_q        <= halt_d;
            req_pending_q <= req_pending_d;
        end
    end

    // Payload storage; contents are only observed through valid pointers
    always_ff @(posedge clk) begin
        pend_mem_q <= pend_mem_d;
        fq_mem_q   <= fq_mem_d;
    end

    // Bus and decode-side outputs
    always_comb begin
        inst_sram_req   = req_c;
        inst_sram_addr  = fetch_pc_q;
        inst_sram_wr    = 1'b0;
        inst_sram_size  = 2'd2;
        inst_sram_wstrb = 4'h0;
        inst_sram_wdata = 32'h0;
        fs_to_ds_valid  = !reset && (q_cnt_q != '0);
        fs_to_ds_bus    = fs_to_ds_valid ? fq_mem_q[fq_rd_q] : 65'd0;
    end

endmodule

// File: tb/tb_if_stage_fq.sv
// Directed bench for if_stage_fq: a per-cycle vector table for reset,
// streaming and back-pressure, plus hand sequences for redirect, misaligned
// PC, stall-while-pending, mid-run reset and address wrap.
`timescale 1ns/1ps
module tb_if_stage_fq;

    localparam logic [31:0] B = 32'hbfc00000;

    logic        clk;
    logic        reset;
    logic        br_stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        ds_allowin;
    logic        fs_to_ds_valid;
    logic [64:0] fs_to_ds_bus;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    int checks = 0;
    int errors = 0;

    if_stage_fq #(.RESET_PC(32'hbfc00000), .FQ_DEPTH(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .br_stall          (br_stall),
        .br_taken          (br_taken),
        .br_target         (br_target),
        .ds_allowin        (ds_allowin),
        .fs_to_ds_valid    (fs_to_ds_valid),
        .fs_to_ds_bus      (fs_to_ds_bus),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        allow;
        logic        aok;
        logic        dok;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [64:0] e_bus;
    } vec_t;

    vec_t vt [17];

    // Instruction word the bench's memory returns for a given address
    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'h5a5a_5a5a;
    endfunction

    function automatic logic [64:0] good(input logic [31:0] pc);
        return {1'b0, inst_of(pc), pc};
    endfunction

    function automatic vec_t mk(input logic rst, input logic allow, input logic aok,
                                input logic dok, input logic [31:0] rdata,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_valid, input logic [31:0] e_pc);
        vec_t v;
        v.rst     = rst;
        v.allow   = allow;
        v.aok     = aok;
        v.dok     = dok;
        v.rdata   = rdata;
        v.e_req   = e_req;
        v.e_addr  = e_addr;
        v.e_valid = e_valid;
        v.e_bus   = e_valid ? good(e_pc) : 65'd0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_req(input string name, input logic e_req, input logic [31:0] e_addr);
        chk({name, "_req"}, 65'(inst_sram_req), 65'(e_req));
        if (e_req) chk({name, "_addr"}, 65'(inst_sram_addr), 65'(e_addr));
    endtask

    task automatic chk_out(input string name, input logic e_valid, input logic [64:0] e_bus);
        chk({name, "_valid"}, 65'(fs_to_ds_valid), 65'(e_valid));
        chk({name, "_bus"}, fs_to_ds_bus, e_bus);
    endtask

    // Apply inputs just after a rising edge, then move to the falling edge
    task automatic drive(input logic rst, input logic stall, input logic taken,
                         input logic [31:0] tgt, input logic allow, input logic aok,
                         input logic dok, input logic [31:0] rd);
        reset             = rst;
        br_stall          = stall;
        br_taken          = taken;
        br_target         = tgt;
        ds_allowin        = allow;
        inst_sram_addr_ok = aok;
        inst_sram_data_ok = dok;
        inst_sram_rdata   = rd;
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        adv();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        adv();
    endtask

    initial begin
        reset = 1'b1; br_stall = 1'b0; br_taken = 1'b0; br_target = 32'h0;
        ds_allowin = 1'b1; inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0;
        inst_sram_rdata = 32'h0;

        //        rst allow aok dok rdata             req addr    valid pc
        vt[0]  = mk(1, 1, 0, 0, 32'h0,              0, 32'h0,    0, 32'h0);
        vt[1]  = mk(1, 1, 0, 0, 32'h0,              0, 32'h0,    0, 32'h0);
        vt[2]  = mk(0, 1, 1, 0, 32'h0,              1, B,        0, 32'h0);
        vt[3]  = mk(0, 1, 1, 1, inst_of(B),         1, B+32'h04, 0, 32'h0);
        vt[4]  = mk(0, 1, 1, 1, inst_of(B+32'h04),  1, B+32'h08, 1, B);
        vt[5]  = mk(0, 1, 1, 1, inst_of(B+32'h08),  1, B+32'h0c, 1, B+32'h04);
        vt[6]  = mk(0, 0, 1, 1, inst_of(B+32'h0c),  1, B+32'h10, 1, B+32'h08);
        vt[7]  = mk(0, 0, 1, 1, inst_of(B+32'h10),  1, B+32'h14, 1, B+32'h08);
        vt[8]  = mk(0, 0, 1, 1, inst_of(B+32'h14),  0, 32'h0,    1, B+32'h08);
        vt[9]  = mk(0, 0, 1, 0, 32'h0,              0, 32'h0,    1, B+32'h08);
        vt[10] = mk(0, 1, 1, 0, 32'h0,              0, 32'h0,    1, B+32'h08);
        vt[11] = mk(0, 1, 1, 0, 32'h0,              1, B+32'h18, 1, B+32'h0c);
        vt[12] = mk(0, 1, 1, 1, inst_of(B+32'h18),  1, B+32'h1c, 1, B+32'h10);
        vt[13] = mk(0, 1, 0, 1, inst_of(B+32'h1c),  1, B+32'h20, 1, B+32'h14);
        vt[14] = mk(0, 1, 0, 0, 32'h0,              1, B+32'h20, 1, B+32'h18);
        vt[15] = mk(0, 1, 0, 0, 32'h0,              1, B+32'h20, 1, B+32'h1c);
        vt[16] = mk(0, 1, 0, 0, 32'h0,              1, B+32'h20, 0, 32'h0);

        adv();

        // Reset, streaming at one per cycle, back-pressure to a full queue
        for (int i = 0; i < 17; i++) begin
            drive(vt[i].rst, 1'b0, 1'b0, 32'h0, vt[i].allow, vt[i].aok, vt[i].dok, vt[i].rdata);
            chk_req($sformatf("vec%0d", i), vt[i].e_req, vt[i].e_addr);
            chk_out($sformatf("vec%0d", i), vt[i].e_valid, vt[i].e_bus);
            if (i == 2) begin
                chk("const_bus", {inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata},
                    {1'b0, 2'd2, 4'h0, 32'h0});
            end
            adv();
        end

        // Redirect with three requests outstanding and data_ok in the branch cycle
        do_reset();
        drive(0, 0, 0, 32'h0, 1, 1, 0, 32'h0);            chk_req("r0", 1, B);          adv();
        drive(0, 0, 0, 32'h0, 1, 1, 0, 32'h0);            chk_req("r1", 1, B+32'h4);    adv();
        drive(0, 0, 0, 32'h0, 1, 1, 0, 32'h0);            chk_req("r2", 1, B+32'h8);    adv();
        drive(0, 0, 1, 32'h1000, 1, 0, 1, inst_of(B));
        chk_req("r3", 1, B+32'hc); chk_out("r3", 0, 65'd0);                              adv();
        drive(0, 0, 0, 32'h0, 1, 0, 1, inst_of(B+32'h4));
        chk_req("r4", 1, 32'h1000); chk_out("r4", 0, 65'd0);                             adv();
        drive(0, 0, 0, 32'h0, 1, 1, 1, inst_of(B+32'h8));
        chk_req("r5", 1, 32'h1000); chk_out("r5", 0, 65'd0);                             adv();
        drive(0, 0, 0, 32'h0, 1, 0, 1, inst_of(32'h1000));
        chk_req("r6", 1, 32'h1004); chk_out("r6", 0, 65'd0);                             adv();
        drive(0, 0, 0, 32'h0, 1, 0, 0, 32'h0);            chk_out("r7", 1, good(32'h1000)); adv();
        drive(0, 0, 0, 32'h0, 1, 0, 0, 32'h0);            chk_out("r8", 0, 65'd0);       adv();

        // Misaligned redirect: one adel entry, idle, then recovery
        drive(0, 0, 1, 32'h1002, 1, 0, 0, 32'h0);         chk_req("m0", 1, 32'h1004);   adv();
        drive(0, 0, 0, 32'h0, 1, 1, 0, 32'h0);
        chk_req("m1", 0, 32'h0); chk_out("m1", 0, 65'd0);                                adv();
        drive(0, 0, 0, 32'h0, 1, 1, 0, 32'h0);
        chk_req("m2", 0, 32'h0); chk_out("m2", 1, {1'b1, 32'h0, 32'h1002});              adv();
        drive(0, 0, 0, 32'h0, 1, 1, 0, 32'h0);
        chk_req("m3", 0, 32'h0); chk_out("m3", 0, 65'd0);                                adv();
        drive(0, 0, 0, 32'h0, 1, 1, 0, 32'h0);
        chk_req("m4", 0, 32'h0); chk_out("m4", 0, 65'd0);                                adv();
        drive(0, 0, 1, 32'h2000, 1, 0, 0, 32'h0);         chk_req("m5", 0, 32'h0);       adv();
        drive(0, 0, 0, 32'h0, 1, 1, 0, 32'h0);            chk_req("m6", 1, 32'h2000);   adv();
        drive(0, 0, 0, 32'h0, 1, 0, 1, inst_of(32'h2000));
        chk_req("m7", 1, 32'h2004); chk_out("m7", 0, 65'd0);                             adv();
        drive(0, 0, 0, 32'h0, 1, 0, 0, 32'h0);            chk_out("m8", 1, good(32'h2000)); adv();

        // Stall while a request is pending, addr_ok delayed three cycles
        do_reset();
        drive(0, 0, 0, 32'h0, 1, 0, 0, 32'h0);            chk_req("s0", 1, B);          adv();
        drive(0, 1, 0, 32'h0, 1, 0, 0, 32'h0);            chk_req("s1", 1, B);          adv();
        drive(0, 1, 0, 32'h0, 1, 0, 0, 32'h0);            chk_req("s2", 1, B);          adv();
        drive(0, 1, 0, 32'h0, 1, 1, 0, 32'h0);            chk_req("s3", 1, B);          adv();
        drive(0, 1, 0, 32'h0, 1, 1, 0, 32'h0);            chk_req("s4", 0, 32'h0);      adv();
        drive(0, 1, 0, 32'h0, 1, 1, 1, inst_of(B));       chk_req("s5", 0, 32'h0);      adv();
        drive(0, 1, 0, 32'h0, 1, 0, 0, 32'h0);
        chk_req("s6", 0, 32'h0); chk_out("s6", 1, good(B));                              adv();
        drive(0, 0, 0, 32'h0, 1, 1, 0, 32'h0);            chk_req("s7", 1, B+32'h4);    adv();
        drive(0, 0, 0, 32'h0, 1, 1, 0, 32'h0);            chk_req("s8", 1, B+32'h8);    adv();

        // Reset with two requests in flight; stragglers afterwards are ignored
        drive(1, 0, 0, 32'h0, 1, 1, 1, inst_of(B+32'h4));
        chk_req("x0", 0, 32'h0); chk_out("x0", 0, 65'd0);                                adv();
        drive(0, 0, 0, 32'h0, 1, 0, 1, inst_of(B+32'h8));
        chk_req("x1", 1, B); chk_out("x1", 0, 65'd0);                                    adv();
        drive(0, 0, 0, 32'h0, 1, 0, 0, 32'h0);
        chk_req("x2", 1, B); chk_out("x2", 0, 65'd0);                                    adv();

        // Fetch address wraps modulo 2^32
        drive(0, 0, 1, 32'hffff_fffc, 1, 0, 0, 32'h0);    chk_req("w0", 1, B);          adv();
        drive(0, 0, 0, 32'h0, 1, 1, 0, 32'h0);            chk_req("w1", 1, 32'hffff_fffc); adv();
        drive(0, 0, 0, 32'h0, 1, 0, 1, inst_of(32'hffff_fffc));
        chk_req("w2", 1, 32'h0);                                                          adv();
        drive(0, 0, 0, 32'h0, 1, 0, 0, 32'h0);            chk_out("w3", 1, good(32'hffff_fffc)); adv();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
